// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared digit type, display limits and converter FSM states
package display_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int NUM_DIGITS     = 4;
  localparam int DISP_MAX       = 9999;
  localparam int BCD_ACC_DIGITS = 5;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } b2b_state_t;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble per-digit correction: add 3 when digit >= 5
module bcd_add3
  import display_pkg::*;
(
  input  bcd_digit_t i_digit,
  output bcd_digit_t o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - one-bit-per-cycle binary to 4-digit BCD converter; BIN2BCD_SAT_EN saturates overflow to 9999
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] bin,
  output logic [3:0]       num1,
  output logic [3:0]       num2,
  output logic [3:0]       num3,
  output logic [3:0]       num4,
  output logic             done,
  output logic             ovf
);

  localparam int ACC_W  = BCD_ACC_DIGITS * 4;
  localparam int DISP_W = NUM_DIGITS * 4;
  localparam int CNT_W  = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  generate
    if (BIN_W < 14 || BIN_W > 16) begin : g_bad_width
      $error("bin2bcd_seq: BIN_W must be in 14..16");
    end
  endgenerate

  b2b_state_t             r_state;
  b2b_state_t             w_state_nxt;
  logic [ACC_W-1:0]       r_acc;
  logic [BIN_W-1:0]       r_sh;
  logic [CNT_W-1:0]       r_cnt;
  logic [3:0]             r_num1, r_num2, r_num3, r_num4;
  logic                   r_ovf;

  logic [ACC_W-1:0]       w_acc_adj;
  logic [ACC_W+BIN_W-1:0] w_shifted;
  logic [ACC_W-1:0]       w_res;
  logic                   w_ovf;
  logic [DISP_W-1:0]      w_disp;

  generate
    for (genvar gi = 0; gi < BCD_ACC_DIGITS; gi++) begin : g_add3
      bcd_add3 u_add3 (
        .i_digit (r_acc[gi*4 +: 4]),
        .o_digit (w_acc_adj[gi*4 +: 4])
      );
    end
  endgenerate

  // w_res is the accumulator as it will stand after this cycle's shift,
  // so the final shift and the output capture share one edge.
  assign w_shifted = {w_acc_adj, r_sh} << 1;
  assign w_res     = w_shifted[ACC_W+BIN_W-1 -: ACC_W];
  assign w_ovf     = |w_res[ACC_W-1 -: 4];

`ifdef BIN2BCD_SAT_EN
  assign w_disp = w_ovf ? {NUM_DIGITS{4'd9}} : w_res[DISP_W-1:0];
`else
  assign w_disp = w_res[DISP_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = CONV;
      CONV:    if (r_cnt == CNT_LAST) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_sh   <= '0;
      r_cnt  <= '0;
      r_num1 <= '0;
      r_num2 <= '0;
      r_num3 <= '0;
      r_num4 <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (r_state == IDLE && in_valid) begin
        r_sh  <= bin;
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_state == CONV) begin
        {r_acc, r_sh} <= w_shifted;
        r_cnt         <= r_cnt + 1'b1;
        if (r_cnt == CNT_LAST) begin
          {r_num1, r_num2, r_num3, r_num4} <= w_disp;
          r_ovf <= w_ovf;
        end
      end
    end
  end

  assign in_ready = (r_state == IDLE);
  assign done     = (r_state == DONE);
  assign num1     = r_num1;
  assign num2     = r_num2;
  assign num3     = r_num3;
  assign num4     = r_num4;
  assign ovf      = r_ovf;

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter that sits directly upstream of the 7-segment display driver. It accepts an unsigned binary count, such as a recognition result or a tally, over a valid/ready handshake. It converts the value with a one-bit-per-cycle shift-and-add-3 (double-dabble) engine and presents four registered BCD digits on `num1`..`num4`, which connect 1:1 to the display driver's digit inputs. The outputs hold their last value during a conversion, so the display never flickers through intermediate states.

## Interface
- `BIN_W`, default 14: binary input width. Legal range is 14..16; elaboration fails outside this range.
- `clk`  in  1: single clock for all logic.
- `rst_n`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid`  in  1: `bin` is valid this cycle.
- `in_ready`  out  1: converter is idle and can accept a value.
- `bin`  in  BIN_W: unsigned value to convert.
- `num1`  out  4: thousands digit (most significant).
- `num2`  out  4: hundreds digit.
- `num3`  out  4: tens digit.
- `num4`  out  4: units digit.
- `done`  out  1: one-cycle pulse; `num1`..`num4` and `ovf` updated this cycle.
- `ovf`  out  1: the last converted value exceeded 9999; held until the next `done`.

## Operation
- FSM has three states: IDLE, CONV, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, load `bin` into the shift register, clear the 5-digit (20-bit) BCD accumulator, clear the iteration counter, and go to CONV.
- CONV:
  - `in_ready`=0.
  - Each cycle, add 3 to every BCD digit ≥5, then shift the {BCD, bin} register left by 1 bit.
  - The counter counts 0..BIN_W-1. After the BIN_W-th shift, go to DONE.
- DONE:
  - Register the digits into `num1`..`num4`.
  - Set `ovf` to (value > 9999).
  - Assert `done` for this single cycle, then return to IDLE.
- `in_valid` while not in IDLE is ignored. The upstream must hold `in_valid` until it sees `in_ready`; a value is never queued.
- Overflow handling (value > 9999) depends on the macro; see Configuration.
- Digit ordering is fixed: `num1` is the MSD and `num4` is the LSD.

## Timing
- Reset values: `num1`..`num4`=0, `done`=0, `ovf`=0, `in_ready`=1, FSM=IDLE, counter=0.
- Accept at edge T:
  - CONV occupies cycles T+1..T+BIN_W.
  - DONE is cycle T+BIN_W+1, so `done` is high in cycle T+15 for BIN_W=14.
  - `in_ready` rises in cycle T+BIN_W+2.
- Throughput: one conversion per BIN_W+2 cycles, i.e. 16 cycles for BIN_W=14.
- `num1`..`num4` and `ovf` change only at the edge that enters DONE and are stable at all other times.
- Reset asserted mid-conversion:
  - The next edge returns everything to reset values.
  - The partial result is discarded.
  - `done` does not pulse.
- `in_valid` in the same cycle that DONE returns to IDLE is not accepted, because `in_ready`=0 in DONE. It is accepted in the following cycle.
- Width rules:
  - Add-3 operates per 4-bit digit, with compare ≥5 and 4-bit add.
  - The 5th (ten-thousands) digit exists only internally.
  - `ovf` = (ten-thousands digit ≠ 0).

## Configuration
- `BIN2BCD_SAT_EN` defined: when `ovf`=1, the outputs saturate to `num1`..`num4` = 9,9,9,9.
- `BIN2BCD_SAT_EN` undefined: the outputs show the value modulo 10000, with the ten-thousands digit dropped. `ovf` still asserts.
- `ovf` behaviour is identical in both builds.

## Structure
- Package `display_pkg` contains:
  - typedef `bcd_digit_t` (logic [3:0]).
  - constants `NUM_DIGITS`=4, `DISP_MAX`=9999, `BCD_ACC_DIGITS`=5.
  - FSM state enum `b2b_state_t`.
- Sub-module `bcd_add3`: combinational per-digit correction (in ≥5 ? in+3 : in). Instantiated 5× in a generate loop.

## Test plan
- Reset check: assert `rst_n`=0 for 3 cycles, then release. Expect `num1`..`num4`=0, `done`=0, `ovf`=0, `in_ready`=1.
- Basic conversion: present `bin`=1234 with `in_valid`. Expect `done` exactly 15 cycles after accept, digits 1,2,3,4, `ovf`=0. Also present `bin`=0 and expect 0,0,0,0.
- Boundary: convert 9999. Expect 9,9,9,9 with `ovf`=0.
- Overflow: convert 12345.
  - Build with `BIN2BCD_SAT_EN`: expect 9,9,9,9 with `ovf`=1.
  - Build without it: expect 2,3,4,5 with `ovf`=1.
- Busy input ignored: start a conversion of 42. Change `bin` to 77 with `in_valid` held high through CONV. Expect the first result to be 0,0,4,2. Expect 77 to be accepted in the first cycle `in_ready`=1, with its result 0,0,7,7 arriving 16 cycles after the first `done`.
- Reset mid-conversion: after converting 1234, start a conversion of 5678 and pull `rst_n` low at cycle T+7. Expect no `done` pulse, outputs cleared to 0, and `in_ready`=1 after release.
